// File: rtl/divider_arb_pkg.sv
// Shared types and helpers for the divider arbiter.
package divider_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_picker
  import divider_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int unsigned     j;
  logic [ID_W-1:0] jj;

  // Scan ptr, ptr+1, ... modulo N and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(ptr) + k) % N;
      jj = ID_W'(j);
      if (req[jj] && !any) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one start/done iterative divider among
// NUM_REQ requesters; one operation in flight, result held until accepted.
module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [WIDTH-1:0]           resp_quotient,
  output logic [WIDTH-1:0]           resp_remainder,
  output logic                       resp_div_zero,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder
);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic                dz_q;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [WIDTH-1:0]    sel_dividend;
  logic [WIDTH-1:0]    sel_divisor;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is offered only while idle; it always covers a valid bit, so any
  // offered grant is also a completed handshake on the next edge.
  always_comb begin
    req_ready    = (state == IDLE) ? pick_grant : '0;
    sel_dividend = req_dividend[pick_idx*WIDTH +: WIDTH];
    sel_divisor  = req_divisor[pick_idx*WIDTH +: WIDTH];
  end

  // Sequencer: accept, pulse start, wait for done, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      id_q           <= '0;
      dz_q           <= 1'b0;
      resp_valid     <= 1'b0;
      resp_id        <= '0;
      resp_quotient  <= '0;
      resp_remainder <= '0;
      resp_div_zero  <= 1'b0;
      div_start      <= 1'b0;
      div_dividend   <= '0;
      div_divisor    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            id_q         <= pick_idx;
            dz_q         <= (sel_divisor == '0);
            div_start    <= 1'b1;
            state        <= ISSUE;
          end
        end
        // div_done still reflects a previous operation here; not sampled.
        ISSUE: begin
          div_start <= 1'b0;
          state     <= BUSY;
        end
        BUSY: begin
          if (div_done) begin
            resp_quotient  <= div_quotient;
            resp_remainder <= div_remainder;
            resp_id        <= id_q;
            resp_div_zero  <= dz_q;
            resp_valid     <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + ID_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
